// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pkg
//  Brief    : Shared HD44780 instruction codes, FSM state encodings and
//             helpers for the LCD row writer.
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // HD44780 instruction bytes (rs = 0)
  localparam logic [7:0] LCD_FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] LCD_DISP_ON         = 8'h0C;
  localparam logic [7:0] LCD_CLEAR           = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] LCD_LINE1_ADDR      = 8'h80;
  localparam logic [7:0] LCD_LINE2_ADDR      = 8'hC0;

  // Number of entries in the init sequence, minus one
  localparam logic [2:0] INIT_LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_INIT    = 3'd1,
    ST_ADDR1   = 3'd2,
    ST_CHAR1   = 3'd3,
    ST_ADDR2   = 3'd4,
    ST_CHAR2   = 3'd5
  } top_state_t;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SETUP  = 2'd1,
    TX_STROBE = 2'd2,
    TX_WAIT   = 2'd3
  } tx_state_t;

  // Init instruction for a given sequence index. The function-set command is
  // deliberately sent twice, as the controller may still be in its reset mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = LCD_FUNC_8BIT_2LINE;
      3'd1:    init_cmd = LCD_FUNC_8BIT_2LINE;
      3'd2:    init_cmd = LCD_DISP_ON;
      3'd3:    init_cmd = LCD_CLEAR;
      default: init_cmd = LCD_ENTRY_INC;
    endcase
  endfunction

  // Character at a column; column 0 lives in the top byte of the row vector.
  function automatic logic [7:0] row_char(input logic [127:0] row,
                                          input logic [3:0]   col);
    row_char = row[{(4'd15 - col), 3'b000} +: 8];
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_byte_tx
//  Brief    : Sends one byte on the HD44780 8-bit bus: setup cycle, enable
//             strobe, then a post-strobe wait (longer for the clear command).
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES         = 5,
  parameter int WAIT_CYCLES       = 500,
  parameter int CLEAR_WAIT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data_byte,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  tx_state_t   state, next_state;
  logic [31:0] cnt;
  logic [31:0] wait_last;

  // The clear command needs a much longer settle time than everything else
  assign wait_last = (!lcd_rs && (lcd_data == LCD_CLEAR)) ? 32'(CLEAR_WAIT_CYCLES - 1)
                                                          : 32'(WAIT_CYCLES - 1);

  assign busy   = (state != TX_IDLE);
  assign lcd_en = (state == TX_STROBE);

  // State register, phase counter and bus latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      cnt      <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      state <= next_state;
      if ((state != next_state) || (state == TX_IDLE))
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
      // rs/data are only loaded on acceptance, so they stay put all transaction
      if ((state == TX_IDLE) && start) begin
        lcd_rs   <= rs;
        lcd_data <= data_byte;
      end
    end
  end

  // Phase sequencing and completion pulse
  always_comb begin
    next_state = state;
    done       = 1'b0;
    case (state)
      TX_IDLE:   if (start) next_state = TX_SETUP;
      TX_SETUP:  next_state = TX_STROBE;
      TX_STROBE: if (cnt == 32'(EN_CYCLES - 1)) next_state = TX_WAIT;
      TX_WAIT: begin
        if (cnt == wait_last) begin
          done       = 1'b1;
          next_state = TX_IDLE;
        end
      end
      default:   next_state = TX_IDLE;
    endcase
  end

endmodule : lcd_byte_tx
`default_nettype wire

// File: rtl/lcd_row_writer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_row_writer
//  Brief    : Powers up and initialises a 16x2 HD44780 LCD, then refreshes
//             both rows continuously from a per-frame row snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_row_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES    = 150000,
  parameter int EN_CYCLES         = 5,
  parameter int WAIT_CYCLES       = 500,
  parameter int CLEAR_WAIT_CYCLES = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  top_state_t   state, next_state;
  logic [31:0]  pwr_cnt;
  logic [2:0]   init_idx;
  logic [3:0]   col;
  logic [127:0] snap1, snap2;
  logic         tx_start, tx_rs, tx_busy, tx_done;
  logic [7:0]   tx_byte;
  logic         last_col;

  assign lcd_rw   = 1'b0;
  assign last_col = (col == 4'd15);

  lcd_byte_tx #(
    .EN_CYCLES         (EN_CYCLES),
    .WAIT_CYCLES       (WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (tx_start),
    .rs        (tx_rs),
    .data_byte (tx_byte),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .busy      (tx_busy),
    .done      (tx_done)
  );

  // State register plus the counters, snapshots and status flags it drives
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_POWERUP;
      pwr_cnt    <= '0;
      init_idx   <= '0;
      col        <= '0;
      snap1      <= '0;
      snap2      <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      frame_done <= (state == ST_CHAR2) && tx_done && last_col;
      if (state == ST_POWERUP)
        pwr_cnt <= pwr_cnt + 32'd1;
      if ((state == ST_INIT) && tx_done) begin
        init_idx <= init_idx + 3'd1;
        if (init_idx == INIT_LAST_IDX)
          init_done <= 1'b1;
      end
      // Column counter wraps 15 -> 0 on the same edge the state advances
      if (((state == ST_CHAR1) || (state == ST_CHAR2)) && tx_done)
        col <= col + 4'd1;
      // Snapshot taken on ADDR1 entry so a whole frame shows one row version
      if ((next_state == ST_ADDR1) && (state != ST_ADDR1)) begin
        snap1 <= row1;
        snap2 <= row2;
      end
    end
  end

  // Next-state logic and byte selection for the transmitter
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    tx_rs      = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      ST_POWERUP: begin
        if (pwr_cnt == 32'(POWERUP_CYCLES - 1)) next_state = ST_INIT;
      end
      ST_INIT: begin
        tx_start = !tx_busy;
        tx_byte  = init_cmd(init_idx);
        if (tx_done && (init_idx == INIT_LAST_IDX)) next_state = ST_ADDR1;
      end
      ST_ADDR1: begin
        tx_start = !tx_busy;
        tx_byte  = LCD_LINE1_ADDR;
        if (tx_done) next_state = ST_CHAR1;
      end
      ST_CHAR1: begin
        tx_start = !tx_busy;
        tx_rs    = 1'b1;
        tx_byte  = row_char(snap1, col);
        if (tx_done && last_col) next_state = ST_ADDR2;
      end
      ST_ADDR2: begin
        tx_start = !tx_busy;
        tx_byte  = LCD_LINE2_ADDR;
        if (tx_done) next_state = ST_CHAR2;
      end
      ST_CHAR2: begin
        tx_start = !tx_busy;
        tx_rs    = 1'b1;
        tx_byte  = row_char(snap2, col);
        if (tx_done && last_col) next_state = ST_ADDR1;
      end
      default: next_state = ST_POWERUP;
    endcase
  end

endmodule : lcd_row_writer
`default_nettype wire
